// File: rtl/path_dec_pkg.sv
// path_dec_pkg: shared constants and helpers for the path direction decoder.
//   - Direction codes used by the maze datapath (DIR_*).
//   - ORIGIN_LOC: the datapath start cell.
//   - state_t: decoder FSM encoding.
//   - classify_step(): inverse of dir->location stepping, with legality check.
package path_dec_pkg;

    localparam logic [1:0] DIR_YDEC = 2'b00;
    localparam logic [1:0] DIR_XINC = 2'b01;
    localparam logic [1:0] DIR_XDEC = 2'b10;
    localparam logic [1:0] DIR_YINC = 2'b11;

    localparam logic [7:0] ORIGIN_LOC = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_DRAIN = 2'b10,
        ST_ERR   = 2'b11
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] dir;
    } step_t;

    // A step is legal only when exactly one nibble moves by one without
    // wrapping; identical locations fall through every branch as illegal.
    function automatic step_t classify_step(input logic [7:0] prev_loc,
                                            input logic [7:0] cur_loc);
        step_t      res;
        logic [3:0] px;
        logic [3:0] py;
        logic [3:0] cx;
        logic [3:0] cy;
        px = prev_loc[7:4];
        py = prev_loc[3:0];
        cx = cur_loc[7:4];
        cy = cur_loc[3:0];
        res.legal = 1'b0;
        res.dir   = DIR_YDEC;
        if (px == cx) begin
            if ((py != 4'h0) && (cy == (py - 4'h1))) begin
                res.legal = 1'b1;
                res.dir   = DIR_YDEC;
            end else if ((py != 4'hF) && (cy == (py + 4'h1))) begin
                res.legal = 1'b1;
                res.dir   = DIR_YINC;
            end else begin
                res.legal = 1'b0;
            end
        end else if (py == cy) begin
            if ((px != 4'hF) && (cx == (px + 4'h1))) begin
                res.legal = 1'b1;
                res.dir   = DIR_XINC;
            end else if ((px != 4'h0) && (cx == (px - 4'h1))) begin
                res.legal = 1'b1;
                res.dir   = DIR_XDEC;
            end else begin
                res.legal = 1'b0;
            end
        end else begin
            res.legal = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/path_dir_decoder_fifo.sv
// dir_fifo: DEPTH x 2-bit synchronous FIFO for direction codes.
// Ports: clk, rst_n (async active-low), flush (sync clear, wins over push/pop),
//        push/wdata, pop/rdata (head, valid when !empty), full, empty.
// Push while full and pop while empty are ignored.
module dir_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic [1:0] wdata,
    input  logic       pop,
    output logic [1:0] rdata,
    output logic       full,
    output logic       empty
);
    import path_dec_pkg::*;

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    mem_q [DEPTH];
    logic          do_push_s;
    logic          do_pop_s;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == {(AW+1){1'b0}});
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and occupancy update; flush returns everything to empty.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; cleared on reset so the head never shows X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else if (do_push_s && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/path_dir_decoder.sv
// path_dir_decoder: turns a replayed stream of maze locations {x[7:4],y[3:0]}
// back into 2-bit direction codes, buffers them in a FIFO, flags illegal
// steps (sticky stepErr) and pulses pathDone once a finished path drains.
// Ports: clk, rst (async active-low), restart (sync clear),
//        locIn/locValid/locReady/pathEnd (location input handshake),
//        dirOut/dirValid/dirReady (direction output handshake),
//        stepCount (saturating pushes this path), stepErr, pathDone.
// Optional: define PATH_DEC_ORIGIN_CHECK_EN to require the first location of
// every path to be ORIGIN_LOC; otherwise any first location is the origin.
module path_dir_decoder #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [7:0]       locIn,
    input  logic             locValid,
    output logic             locReady,
    input  logic             pathEnd,
    output logic [1:0]       dirOut,
    output logic             dirValid,
    input  logic             dirReady,
    output logic [CNT_W-1:0] stepCount,
    output logic             stepErr,
    output logic             pathDone
);
    import path_dec_pkg::*;

    state_t           state_q, state_d;
    logic [7:0]       prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             accept_s;
    logic             origin_ok_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    step_t            step_s;

    assign accept_s  = locValid && locReady;
    assign pop_s     = dirValid && dirReady;
    assign step_s    = classify_step(prev_q, locIn);
    assign dirValid  = !fifo_empty_s;
    assign stepCount = cnt_q;
    assign stepErr   = err_q;
    assign pathDone  = done_q;

`ifdef PATH_DEC_ORIGIN_CHECK_EN
    assign origin_ok_s = (locIn == ORIGIN_LOC);
`else
    assign origin_ok_s = 1'b1;
`endif

    // Input readiness: a pop in the same cycle deliberately does not free a slot.
    always_comb begin
        locReady = 1'b0;
        case (state_q)
            ST_IDLE:  locReady = 1'b1;
            ST_TRACK: locReady = !fifo_full_s;
            default:  locReady = 1'b0;
        endcase
    end

    // Next-state, path bookkeeping and FIFO control.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        push_s  = 1'b0;
        flush_s = 1'b0;
        if (restart) begin
            state_d = ST_IDLE;
            prev_d  = 8'h00;
            cnt_d   = {CNT_W{1'b0}};
            err_d   = 1'b0;
            flush_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && origin_ok_s) begin
                        prev_d  = locIn;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = pathEnd ? ST_DRAIN : ST_TRACK;
                    end else if (accept_s) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        flush_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TRACK: begin
                    if (accept_s && step_s.legal) begin
                        push_s  = 1'b1;
                        prev_d  = locIn;
                        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                        state_d = pathEnd ? ST_DRAIN : ST_TRACK;
                    end else if (accept_s) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        flush_s = 1'b1;
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_s) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM and path bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            prev_q  <= 8'h00;
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .flush (flush_s),
        .push  (push_s),
        .wdata (step_s.dir),
        .pop   (pop_s),
        .rdata (dirOut),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

endmodule

// File: tb/tb_path_dir_decoder.sv
// tb_path_dir_decoder: directed self-checking bench for path_dir_decoder.
module tb_path_dir_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] locIn = 8'h00;
    logic       locValid = 1'b0;
    logic       locReady;
    logic       pathEnd = 1'b0;
    logic [1:0] dirOut;
    logic       dirValid;
    logic       dirReady = 1'b0;
    logic [7:0] stepCount;
    logic       stepErr;
    logic       pathDone;

    int n_cmp = 0;
    int n_fail = 0;

    path_dir_decoder #(.DEPTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .locIn(locIn), .locValid(locValid), .locReady(locReady), .pathEnd(pathEnd),
        .dirOut(dirOut), .dirValid(dirValid), .dirReady(dirReady),
        .stepCount(stepCount), .stepErr(stepErr), .pathDone(pathDone)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one location for one cycle (caller ensures locReady).
    task automatic drive_loc(input logic [7:0] loc, input logic last);
        locIn    = loc;
        pathEnd  = last;
        locValid = 1'b1;
        tick();
        locValid = 1'b0;
        pathEnd  = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // Legal walk 00,10,20,30,31,32,33.
    task automatic walk_to_33();
        drive_loc(8'h00, 1'b0);
        drive_loc(8'h10, 1'b0);
        drive_loc(8'h20, 1'b0);
        drive_loc(8'h30, 1'b0);
        drive_loc(8'h31, 1'b0);
        drive_loc(8'h32, 1'b0);
        drive_loc(8'h33, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_cmp++; if (dirValid !== 1'b0) begin n_fail++; $display("FAIL reset_dirValid got %b want 0", dirValid); end
        n_cmp++; if (locReady !== 1'b1) begin n_fail++; $display("FAIL reset_locReady got %b want 1", locReady); end
        n_cmp++; if (stepCount !== 8'd0) begin n_fail++; $display("FAIL reset_stepCount got %0d want 0", stepCount); end
        n_cmp++; if (stepErr !== 1'b0 || pathDone !== 1'b0) begin n_fail++; $display("FAIL reset_flags got err=%b done=%b want 0 0", stepErr, pathDone); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_path();
        dirReady = 1'b1;
        drive_loc(8'h00, 1'b0);
        drive_loc(8'h10, 1'b0);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b01) begin n_fail++; $display("FAIL basic_dir0 got v=%b d=%b want 1 01", dirValid, dirOut); end
        drive_loc(8'h11, 1'b0);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b11) begin n_fail++; $display("FAIL basic_dir1 got v=%b d=%b want 1 11", dirValid, dirOut); end
        drive_loc(8'h21, 1'b1);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b01) begin n_fail++; $display("FAIL basic_dir2 got v=%b d=%b want 1 01", dirValid, dirOut); end
        n_cmp++; if (stepCount !== 8'd3) begin n_fail++; $display("FAIL basic_count got %0d want 3", stepCount); end
        n_cmp++; if (locReady !== 1'b0) begin n_fail++; $display("FAIL basic_drain_ready got %b want 0", locReady); end
        tick();
        n_cmp++; if (dirValid !== 1'b0 || pathDone !== 1'b0) begin n_fail++; $display("FAIL basic_empty got v=%b done=%b want 0 0", dirValid, pathDone); end
        tick();
        n_cmp++; if (pathDone !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", pathDone); end
        tick();
        n_cmp++; if (pathDone !== 1'b0 || locReady !== 1'b1) begin n_fail++; $display("FAIL basic_done_pulse got done=%b rdy=%b want 0 1", pathDone, locReady); end
    endtask

    task automatic test_single_path();
        do_restart();
        drive_loc(8'h00, 1'b1);
        n_cmp++; if (pathDone !== 1'b0 || locReady !== 1'b0 || dirValid !== 1'b0) begin n_fail++; $display("FAIL single_drain got done=%b rdy=%b v=%b want 0 0 0", pathDone, locReady, dirValid); end
        tick();
        n_cmp++; if (pathDone !== 1'b1) begin n_fail++; $display("FAIL single_done got %b want 1", pathDone); end
    endtask

    task automatic test_backpressure();
        int pops;
        int bad;
        int idx;
        bit seen_done;
        bit acc;
        bit pop;
        do_restart();
        dirReady = 1'b0;
        for (int y = 0; y < 9; y++) drive_loc({4'h0, 4'(y)}, 1'b0);
        n_cmp++; if (locReady !== 1'b0 || dirValid !== 1'b1) begin n_fail++; $display("FAIL full_ready got rdy=%b v=%b want 0 1", locReady, dirValid); end
        n_cmp++; if (stepCount !== 8'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", stepCount); end
        locIn = 8'h09; locValid = 1'b1;
        tick(); tick();
        n_cmp++; if (stepCount !== 8'd8 || locReady !== 1'b0) begin n_fail++; $display("FAIL full_hold got cnt=%0d rdy=%b want 8 0", stepCount, locReady); end
        dirReady = 1'b1;
        pops = 0; bad = 0; idx = 9; seen_done = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            acc = locValid && locReady;
            pop = dirValid && dirReady;
            if (pop) begin
                pops++;
                if (dirOut !== 2'b11) bad++;
            end
            tick();
            if (pathDone === 1'b1) seen_done = 1'b1;
            if (acc) begin
                idx++;
                if (idx < 12) begin
                    locIn = {4'h0, 4'(idx)};
                    pathEnd = (idx == 11);
                end else begin
                    locValid = 1'b0;
                    pathEnd = 1'b0;
                end
            end
        end
        n_cmp++; if (!seen_done) begin n_fail++; $display("FAIL drain_timeout got no pathDone want pathDone within 60 cycles"); end
        n_cmp++; if (pops !== 11 || bad !== 0) begin n_fail++; $display("FAIL drain_pops got pops=%0d bad=%0d want 11 0", pops, bad); end
        n_cmp++; if (stepCount !== 8'd11) begin n_fail++; $display("FAIL drain_count got %0d want 11", stepCount); end
        locValid = 1'b0;
    endtask

    task automatic test_error_restart();
        do_restart();
        dirReady = 1'b0;
        drive_loc(8'h00, 1'b0);
        drive_loc(8'h01, 1'b0);
        drive_loc(8'h22, 1'b0);
        n_cmp++; if (stepErr !== 1'b1 || dirValid !== 1'b0 || locReady !== 1'b0) begin n_fail++; $display("FAIL err_state got err=%b v=%b rdy=%b want 1 0 0", stepErr, dirValid, locReady); end
        n_cmp++; if (stepCount !== 8'd1) begin n_fail++; $display("FAIL err_count_kept got %0d want 1", stepCount); end
        tick();
        n_cmp++; if (stepErr !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", stepErr); end
        do_restart();
        n_cmp++; if (stepErr !== 1'b0 || locReady !== 1'b1 || stepCount !== 8'd0) begin n_fail++; $display("FAIL restart_clear got err=%b rdy=%b cnt=%0d want 0 1 0", stepErr, locReady, stepCount); end
        drive_loc(8'h00, 1'b0);
        drive_loc(8'h01, 1'b0);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b11 || stepErr !== 1'b0) begin n_fail++; $display("FAIL restart_origin got v=%b d=%b err=%b want 1 11 0", dirValid, dirOut, stepErr); end
    endtask

    task automatic test_boundaries();
        do_restart();
        dirReady = 1'b1;
        drive_loc(8'h00, 1'b0);
        for (int x = 1; x < 16; x++) drive_loc({4'(x), 4'h0}, 1'b0);
        n_cmp++; if (stepErr !== 1'b0 || dirOut !== 2'b01) begin n_fail++; $display("FAIL walk_x got err=%b d=%b want 0 01", stepErr, dirOut); end
        drive_loc(8'h00, 1'b0);
        n_cmp++; if (stepErr !== 1'b1) begin n_fail++; $display("FAIL wrap_err got %b want 1", stepErr); end
        do_restart();
        walk_to_33();
        drive_loc(8'h33, 1'b0);
        n_cmp++; if (stepErr !== 1'b1) begin n_fail++; $display("FAIL repeat_err got %b want 1", stepErr); end
        do_restart();
        walk_to_33();
        drive_loc(8'h32, 1'b0);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b00) begin n_fail++; $display("FAIL ydec got v=%b d=%b want 1 00", dirValid, dirOut); end
        do_restart();
        walk_to_33();
        drive_loc(8'h43, 1'b0);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b01) begin n_fail++; $display("FAIL xinc got v=%b d=%b want 1 01", dirValid, dirOut); end
        drive_loc(8'h33, 1'b0);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b10 || stepErr !== 1'b0) begin n_fail++; $display("FAIL xdec got v=%b d=%b err=%b want 1 10 0", dirValid, dirOut, stepErr); end
    endtask

    task automatic test_reset_mid_path();
        do_restart();
        dirReady = 1'b0;
        drive_loc(8'h00, 1'b0);
        drive_loc(8'h01, 1'b0);
        drive_loc(8'h02, 1'b0);
        drive_loc(8'h03, 1'b0);
        n_cmp++; if (dirValid !== 1'b1 || stepCount !== 8'd3) begin n_fail++; $display("FAIL mid_fill got v=%b cnt=%0d want 1 3", dirValid, stepCount); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (dirValid !== 1'b0 || stepCount !== 8'd0 || locReady !== 1'b1) begin n_fail++; $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b want 0 0 1", dirValid, stepCount, locReady); end
        rst = 1'b1;
        tick();
        dirReady = 1'b1;
        drive_loc(8'h00, 1'b0);
        drive_loc(8'h10, 1'b1);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b01 || stepCount !== 8'd1) begin n_fail++; $display("FAIL mid_newpath got v=%b d=%b cnt=%0d want 1 01 1", dirValid, dirOut, stepCount); end
        tick(); tick();
        n_cmp++; if (pathDone !== 1'b1) begin n_fail++; $display("FAIL mid_newpath_done got %b want 1", pathDone); end
    endtask

    task automatic test_origin();
        do_restart();
        dirReady = 1'b1;
        drive_loc(8'h12, 1'b0);
`ifdef PATH_DEC_ORIGIN_CHECK_EN
        n_cmp++; if (stepErr !== 1'b1 || locReady !== 1'b0) begin n_fail++; $display("FAIL origin_err got err=%b rdy=%b want 1 0", stepErr, locReady); end
`else
        n_cmp++; if (stepErr !== 1'b0 || locReady !== 1'b1) begin n_fail++; $display("FAIL origin_ok got err=%b rdy=%b want 0 1", stepErr, locReady); end
        drive_loc(8'h13, 1'b0);
        n_cmp++; if (dirValid !== 1'b1 || dirOut !== 2'b11) begin n_fail++; $display("FAIL origin_step got v=%b d=%b want 1 11", dirValid, dirOut); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_path();
        test_single_path();
        test_backpressure();
        test_error_restart();
        test_boundaries();
        test_reset_mid_path();
        test_origin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/path_dir_decoder.md
Name: path_dir_decoder

Overview:
- Consumes the stream of 8-bit mouse locations ({x[7:4], y[3:0]}) that the maze datapath's stack/queue replays on run.
- Converts each consecutive location pair back into the 2-bit direction code the datapath uses, i.e. the inverse of dir→location stepping.
- Buffers the resulting direction codes in a small FIFO for a downstream motor/replay consumer.
- Detects illegal steps and signals end of path.

Parameters:
- DEPTH, 8, direction FIFO entries (power of two, ≥2).
- CNT_W, 8, width of the step counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- restart  input  1  synchronous clear: flush FIFO, return to IDLE
- locIn  input  8  location; x = [7:4], y = [3:0]
- locValid  input  1  locIn valid
- locReady  output  1  decoder accepts locIn this cycle
- pathEnd  input  1  qualifies locIn as the final location of the path
- dirOut  output  2  direction code at FIFO head
- dirValid  output  1  dirOut valid (FIFO not empty)
- dirReady  input  1  consumer takes dirOut
- stepCount  output  CNT_W  directions pushed for the current path, saturating
- stepErr  output  1  sticky illegal-step flag
- pathDone  output  1  one-cycle pulse when a path is fully drained

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, prev=8'h00, stepCount=0, stepErr=0, pathDone=0, dirValid=0, locReady=1.
- Direction encoding (fixed, matches datapath):
  - 2'b00 = y-1
  - 2'b01 = x+1
  - 2'b10 = x-1
  - 2'b11 = y+1
- Adjacency rule:
  - Exactly one coordinate differs, by exactly 1, with no 4-bit wrap. F→0 and 0→F are illegal.
  - An identical location is illegal.
- Transfer: accept occurs when locValid && locReady. The same rule applies on the output side: pop occurs when dirValid && dirReady.
- locReady:
  - 1 in IDLE.
  - 1 in TRACK only when the FIFO is not full. A same-cycle pop does not free a slot for a push.
  - 0 in DRAIN and ERR.
- FSM states: IDLE, TRACK, DRAIN, ERR.
- IDLE:
  - On accept: prev<=locIn, stepCount<=0, no push.
  - Next state is DRAIN if pathEnd, else TRACK.
- TRACK, on accept:
  - Legal step: push the code, prev<=locIn, stepCount+1 (saturating at all-ones). If pathEnd, go to DRAIN.
  - Illegal step: go to ERR.
- DRAIN: when the FIFO is empty, pulse pathDone for 1 cycle and go to IDLE. A single-location path reaches DRAIN with an empty FIFO, so pathDone follows 1 cycle later.
- ERR:
  - stepErr=1; FIFO flushed on entry; dirValid=0.
  - Held until restart or reset. stepCount keeps its value.
- Latency: a location accepted in cycle N produces dirValid=1 with its code at cycle N+1, provided the FIFO was empty.
- FIFO: FIFO order preserved. Simultaneous push/pop when not full: both occur, occupancy unchanged.
- restart=1: same effect as reset except synchronous, and takes priority over any transfer that cycle. Clears stepErr and stepCount.
- Reset asserted mid-path: all state is lost immediately, and outputs take their reset values asynchronously.

Optional Feature:
- Macro: PATH_DEC_ORIGIN_CHECK_EN.
- Defined: the first location accepted in IDLE must equal 8'h00, the datapath start cell. Any other value goes to ERR with stepErr=1, and prev is not updated.
- Undefined: any first location is accepted as the path origin.

Decomposition:
- Package path_dec_pkg:
  - Direction constants DIR_YDEC=2'b00, DIR_XINC=2'b01, DIR_XDEC=2'b10, DIR_YINC=2'b11.
  - ORIGIN_LOC=8'h00.
  - State encoding for IDLE, TRACK, DRAIN, ERR.
- One sub-module dir_fifo: DEPTH x 2-bit synchronous FIFO with flush, full/empty, and async active-low reset.
- The step-classification logic stays inline.

Test Plan:
- Path 00,10,11,21 (pathEnd on 21), dirReady=1 → dirOut 01,11,01 on consecutive cycles; stepCount=3; a single pathDone pulse after the last pop.
- dirReady=0, DEPTH=8, 12 locations along y+1 from 00 → 9 accepted, 8 codes 11 buffered, locReady=0. Raise dirReady → all codes drain and the remaining locations are accepted.
- 00 then 22 → stepErr=1, dirValid=0, locReady=0; pulse restart → stepErr=0, locReady=1, next location taken as the origin.
- F0→00 (wrap) → ERR. Separately, 33→33 (repeat) → ERR. Separately, 33→32 → code 00 and 33→43 → code 01.
- Assert rst mid-path with 3 codes buffered → dirValid=0, stepCount=0, state IDLE immediately; a new path decodes normally.
- First location 8'h12: with PATH_DEC_ORIGIN_CHECK_EN → stepErr=1; without the macro → accepted, and 12→13 yields code 11.
